// File: rtl/hbm_burst_writer.sv
// AXI4 write master that drains a 512-bit valid/ready stream into one HBM pseudo-channel
// as 4 KB-safe INCR bursts. Optional EXEC perf counters are enabled by HBM_WR_PERF_CNT_EN.
module hbm_burst_writer #(
  parameter int DATA_W    = 512,
  parameter int ADDR_W    = 33,
  parameter int MAX_BURST = 16,
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [CNT_W-1:0]    cmd_words,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [3:0]          m_awlen,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [1:0]          m_bresp,
  output logic                busy,
  output logic                done,
  output logic                error
`ifdef HBM_WR_PERF_CNT_EN
  ,
  output logic [31:0]         perf_cycles,
  output logic [31:0]         perf_stall
`endif
);

  localparam int BYTES      = DATA_W / 8;
  localparam int BYTE_SH    = $clog2(BYTES);
  localparam int PAGE_WORDS = 4096 / BYTES;
  localparam int ROOM_W     = $clog2(PAGE_WORDS + 1);
  localparam int LEN_W      = 4;
  localparam int BEAT_W     = LEN_W + 1;
  localparam int PTR_W      = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int OCNT_W     = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_EXEC, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  cmd_addr_q, next_addr;
  logic [CNT_W-1:0]   cmd_words_q, aw_remaining, w_remaining;
  logic [OCNT_W-1:0]  outstanding;
  logic [LEN_W-1:0]   len_mem [MAX_OUTST];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [OCNT_W-1:0]  fifo_cnt;
  logic [LEN_W-1:0]   beat_cnt;
  logic [ROOM_W-1:0]  page_room;
  logic [BEAT_W-1:0]  burst_cap, aw_beats;
  logic               cmd_hs, aw_req, aw_hs, w_active, w_hs, w_last_hs, b_hs;
  logic               fifo_empty, fifo_full, misaligned, exec_done;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Burst size: capped by MAX_BURST, the words left, and the words left in the 4 KB page.
  assign page_room = ROOM_W'(PAGE_WORDS) - ROOM_W'(next_addr[11:BYTE_SH]);
  assign burst_cap = (page_room < ROOM_W'(MAX_BURST)) ? BEAT_W'(page_room) : BEAT_W'(MAX_BURST);
  assign aw_beats  = (aw_remaining < CNT_W'(burst_cap)) ? BEAT_W'(aw_remaining) : burst_cap;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == OCNT_W'(MAX_OUTST));
  assign misaligned = (cmd_addr_q[BYTE_SH-1:0] != '0);

  assign cmd_hs = cmd_valid && cmd_ready;
  assign aw_req = (state == S_EXEC) && (aw_remaining != '0) &&
                  (outstanding < OCNT_W'(MAX_OUTST)) && !fifo_full;
  assign aw_hs  = m_awvalid && m_awready;

  assign m_awvalid = aw_req;
  assign m_awaddr  = next_addr;
  assign m_awlen   = aw_req ? LEN_W'(aw_beats - BEAT_W'(1)) : '0;

  // W is only open while an accepted burst is queued; data flows straight through.
  assign w_active  = (state == S_EXEC) && !fifo_empty;
  assign s_ready   = m_wready && w_active;
  assign m_wvalid  = s_valid && w_active;
  assign m_wdata   = w_active ? s_data : '0;
  assign m_wstrb   = '1;
  assign m_wlast   = w_active && (beat_cnt == len_mem[rd_ptr]);
  assign w_hs      = m_wvalid && m_wready;
  assign w_last_hs = w_hs && m_wlast;

  assign m_bready  = (state != S_IDLE);
  assign b_hs      = m_bvalid && m_bready && (state == S_EXEC);

  assign exec_done = (aw_remaining == '0) && fifo_empty &&
                     (outstanding == '0) && (w_remaining == '0);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every clocked block uses non-blocking assignments so all registers update from the
    // same pre-edge values regardless of evaluation order.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_nxt = S_INIT;
      end
      S_INIT:  state_nxt = (misaligned || (cmd_words_q == '0)) ? S_DONE : S_EXEC;
      S_EXEC:  if (exec_done) state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_addr_q   <= '0;
      cmd_words_q  <= '0;
      next_addr    <= '0;
      aw_remaining <= '0;
      w_remaining  <= '0;
      outstanding  <= '0;
    end else begin
      if (cmd_hs) begin
        cmd_addr_q  <= cmd_addr;
        cmd_words_q <= cmd_words;
      end
      if (state == S_INIT) begin
        next_addr    <= cmd_addr_q;
        aw_remaining <= cmd_words_q;
        w_remaining  <= cmd_words_q;
        outstanding  <= '0;
      end else begin
        if (aw_hs) begin
          next_addr    <= next_addr + (ADDR_W'(aw_beats) << BYTE_SH);
          aw_remaining <= aw_remaining - CNT_W'(aw_beats);
        end
        if (w_hs) w_remaining <= w_remaining - CNT_W'(1);
        unique case ({aw_hs, b_hs})
          2'b10:   outstanding <= outstanding + OCNT_W'(1);
          2'b01:   outstanding <= outstanding - OCNT_W'(1);
          default: outstanding <= outstanding;
        endcase
      end
    end
  end

  // Length FIFO: one entry (awlen) per accepted AW, retired on that burst's wlast.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      if (aw_hs)     wr_ptr <= ptr_inc(wr_ptr);
      if (w_last_hs) rd_ptr <= ptr_inc(rd_ptr);
      unique case ({aw_hs, w_last_hs})
        2'b10:   fifo_cnt <= fifo_cnt + OCNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - OCNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (w_last_hs) beat_cnt <= '0;
      else if (w_hs) beat_cnt <= beat_cnt + LEN_W'(1);
    end
  end

  // NOTE: storage has no reset; the cleared pointers and count keep stale entries unread.
  always_ff @(posedge clk) begin
    if (aw_hs) len_mem[wr_ptr] <= LEN_W'(aw_beats - BEAT_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error <= 1'b0;
    end else if (cmd_hs) begin
      error <= (cmd_addr[BYTE_SH-1:0] != '0);
    end else if (b_hs && (m_bresp != 2'b00)) begin
      error <= 1'b1;
    end
  end

`ifdef HBM_WR_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (cmd_hs) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (state == S_EXEC) begin
      if (perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
      if (m_wvalid && !m_wready && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: doc/hbm_burst_writer.md
Name: hbm_burst_writer

Overview:
- AXI4 write master that drains a valid/ready stream of 512-bit result words from the compute core into one HBM pseudo-channel.
- Counterpart of the core's HBM read path.
- A command gives a 64 B-aligned base address and a word count. The block splits the transfer into INCR bursts of at most 16 beats, never crossing a 4 KB boundary, and reports done/error when all write responses are back.
- Control FSM mirrors the compute-core states IDLE/INIT/EXEC/DONE.

Parameters:
- DATA_W, 512, data/xfer word width in bits; byte count = DATA_W/8 = 64.
- ADDR_W, 33, byte address width.
- MAX_BURST, 16, maximum beats per burst; awlen = beats-1, 4 bits.
- MAX_OUTST, 4, maximum bursts with AW accepted and B not yet received.
- CNT_W, 32, width of the command word count.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_addr  in  ADDR_W  base byte address.
- cmd_words  in  CNT_W  number of 64 B words to write.
- s_valid  in  1  input data valid.
- s_ready  out  1  input data ready.
- s_data  in  DATA_W  input data word.
- m_awvalid  out  1  AXI write-address valid.
- m_awready  in  1  AXI write-address ready.
- m_awaddr  out  ADDR_W  burst start address.
- m_awlen  out  4  burst beats-1.
- m_wvalid  out  1  AXI write-data valid.
- m_wready  in  1  AXI write-data ready.
- m_wdata  out  DATA_W  write data.
- m_wstrb  out  DATA_W/8  write strobes, constant all-ones.
- m_wlast  out  1  last beat of burst.
- m_bvalid  in  1  write-response valid.
- m_bready  out  1  write-response ready, constant 1 outside IDLE.
- m_bresp  in  2  write response code.
- busy  out  1  high while state != IDLE.
- done  out  1  one-cycle pulse on DONE entry.
- error  out  1  sticky until next accepted command.

Behaviour:
- Reset: asynchronous, active-high. All outputs 0 except cmd_ready=1; state=IDLE; counters and burst-length FIFO cleared. Reset mid-transfer abandons the transfer with no flush; the AXI slave is reset alongside.
- IDLE:
  - cmd_valid && cmd_ready latches addr and words, clears error, goes to INIT.
  - If cmd_addr[5:0] != 0: set error, go to DONE.
  - If cmd_words == 0: go to DONE.
- INIT: one cycle. Loads next_addr, aw_remaining = words, w_remaining = words, outstanding = 0. Goes to EXEC.
- EXEC, AW channel:
  - Beats for the next burst = min(MAX_BURST, aw_remaining, (4096 - next_addr[11:0])/64).
  - AW is issued when aw_remaining > 0, outstanding < MAX_OUTST and the length FIFO is not full.
  - m_awvalid/addr/len stay stable until m_awready.
  - On handshake: push beats into the length FIFO (depth MAX_OUTST); next_addr += beats*64; aw_remaining -= beats; outstanding += 1.
- EXEC, W channel:
  - Data is only sent for bursts whose AW has been accepted, i.e. length FIFO non-empty.
  - s_ready = m_wready && FIFO non-empty; m_wvalid = s_valid && FIFO non-empty; combinational pass-through, zero latency.
  - m_wlast = (beat_cnt == FIFO head - 1). On the wlast handshake: pop FIFO, reset beat_cnt to 0.
- EXEC, B channel:
  - Each m_bvalid decrements outstanding.
  - bresp != 2'b00 sets error.
  - If an AW handshake and a B response occur in the same cycle, outstanding is unchanged.
- EXEC exits to DONE when aw_remaining == 0, the FIFO is empty and outstanding == 0.
- DONE: done=1 for exactly one cycle, then IDLE. No new command is accepted in DONE.
- Address wrap: the top of the ADDR_W space is not checked; next_addr wraps modulo 2^ADDR_W.
- s_valid while in IDLE/INIT/DONE: s_ready=0, data held off.

Optional Feature:
- HBM_WR_PERF_CNT_EN
  - Defined: adds output perf_cycles[31:0] and perf_stall[31:0].
  - perf_cycles counts EXEC cycles; perf_stall counts EXEC cycles with m_wvalid && !m_wready.
  - Both saturate at all-ones, clear on command accept, and hold their value after DONE.
  - Undefined: these ports and counters do not exist.

Test Plan:
- cmd addr=0x0, words=40, AXI slave always ready -> AW bursts at 0x0/0x400/0x800 with awlen 15/15/7; 40 W beats, wlast on beats 16/32/40; done pulse; error=0.
- cmd addr=0xFC0, words=3 -> two bursts: 0xFC0 len 0, then 0x1000 len 1; 4 KB boundary never crossed.
- cmd words=0 -> done pulse 2 cycles after accept; no AW or W traffic.
- cmd addr=0x10 -> error=1, done pulse, no AXI traffic; next valid command clears error.
- words=128, m_bvalid withheld, random wready/s_valid -> at most 4 AWs issued before the first B; data order preserved; 8 bursts total; second B carries bresp=2'b10 -> error=1 at done.
- Assert rst during EXEC mid-burst -> all outputs return to reset values asynchronously; a fresh cmd addr=0x0, words=1 then completes normally.
